// File: rtl/trace_pkg.sv
// Shared types and helpers for the output trace capture block.
// Holds the trace entry record and the channel-index width function.
package trace_pkg;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_CH_W   = 4;
  localparam int MAX_TS_W   = 32;

  // One captured sample: watched value, source channel and capture time.
  typedef struct packed {
    logic [MAX_DATA_W-1:0] value;
    logic [MAX_CH_W-1:0]   ch;
    logic [MAX_TS_W-1:0]   ts;
  } trace_entry_t;

  // Width of a channel index; never less than one bit.
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO holding packed trace entries.
// The head word is presented whenever the FIFO is non-empty, and reads as zero when it is empty.
module trace_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             push;
  logic             pop;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign pop   = rd_en & ~empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push  = wr_en & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; occupancy is tracked by the pointers, and the read port is gated by empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];
  assign count   = cnt;

endmodule

// File: rtl/out_trace_capture.sv
// Change-detecting trace capture of NUM_CH watched outputs into a show-ahead FIFO.
// Per-entry timestamps exist only when TRACE_TIMESTAMP_EN is defined; otherwise rd_ts is tied to zero.
module out_trace_capture
  import trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH*DATA_W-1:0]       watch_data,
  input  logic [NUM_CH-1:0]              watch_valid,
  input  logic                           cap_en,
  input  logic                           rd_en,
  input  logic                           clr_ovf,
  output logic                           rd_valid,
  output logic [DATA_W-1:0]              rd_data,
  output logic [ch_width(NUM_CH)-1:0]    rd_ch,
  output logic [TS_W-1:0]                rd_ts,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           overflow
);

  localparam int CH_W = ch_width(NUM_CH);
`ifdef TRACE_TIMESTAMP_EN
  localparam int EW = DATA_W + CH_W + TS_W;
`else
  localparam int EW = DATA_W + CH_W;
`endif

  logic [DATA_W-1:0] last_q     [NUM_CH];
  logic [DATA_W-1:0] pend_val_q [NUM_CH];
  logic [NUM_CH-1:0] first_q;
  logic [NUM_CH-1:0] pend_q;
  logic              overflow_q;

  logic [NUM_CH-1:0] ev;
  logic [NUM_CH-1:0] sel_onehot;
  logic [NUM_CH-1:0] pend_keep;
  logic              sel_found;
  logic [CH_W-1:0]   sel_idx;
  logic [DATA_W-1:0] sel_val;
  logic              wr_ok;
  logic              loss;
  logic              fifo_full;
  logic              fifo_empty;
  logic [EW-1:0]     wr_entry;
  logic [EW-1:0]     rd_entry;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]   ts_q;
  logic [TS_W-1:0]   pend_ts_q [NUM_CH];
  logic [TS_W-1:0]   sel_ts;
`endif

  // NOTE: every combinational output gets a default first, so no path through the loops infers a latch.
  always_comb begin
    ev         = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    sel_val    = '0;
`ifdef TRACE_TIMESTAMP_EN
    sel_ts     = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      ev[i] = cap_en & watch_valid[i] &
              (first_q[i] | (watch_data[i*DATA_W +: DATA_W] != last_q[i]));
    end
    // Scan downwards so the lowest pending channel is the one that wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_found  = 1'b1;
        sel_idx    = CH_W'(i);
        sel_onehot = NUM_CH'(1) << i;
        sel_val    = pend_val_q[i];
`ifdef TRACE_TIMESTAMP_EN
        sel_ts     = pend_ts_q[i];
`endif
      end
    end
  end

  assign wr_ok     = sel_found & (~fifo_full | (rd_en & ~fifo_empty));
  assign pend_keep = pend_q & ~sel_onehot;
  assign loss      = (sel_found & ~wr_ok) | (|(ev & pend_keep));

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q    <= '1;
      pend_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      first_q <= first_q & ~ev;
      pend_q  <= pend_keep | ev;
      // A loss in the same cycle as a clear request wins.
      if (loss)         overflow_q <= 1'b1;
      else if (clr_ovf) overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (ev[i]) begin
        last_q[i]     <= watch_data[i*DATA_W +: DATA_W];
        pend_val_q[i] <= watch_data[i*DATA_W +: DATA_W];
`ifdef TRACE_TIMESTAMP_EN
        pend_ts_q[i]  <= ts_q;
`endif
      end
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + TS_W'(1);
  end

  assign wr_entry = {sel_val, sel_idx, sel_ts};
  assign rd_ts    = rd_entry[TS_W-1:0];
`else
  assign wr_entry = {sel_val, sel_idx};
  assign rd_ts    = '0;
`endif

  trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  assign rd_valid = ~fifo_empty;
  assign rd_data  = rd_entry[EW-1 -: DATA_W];
  assign rd_ch    = rd_entry[EW-DATA_W-1 -: CH_W];
  assign overflow = overflow_q;

endmodule

// File: doc/out_trace_capture.md
OUT_TRACE_CAPTURE -- requirements
Module: out_trace_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each watched output.
REQ-002 SHALL have parameter NUM_CH, default 4, number of watched channels (1..16).
REQ-003 SHALL have parameter DEPTH, default 16, capture FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter TS_W, default 16, timestamp width.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port watch_data  input  NUM_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port watch_valid  input  NUM_CH  per-channel sample qualifier.
REQ-009 SHALL have port cap_en  input  1  capture enable.
REQ-010 SHALL have port rd_en  input  1  pop request.
REQ-011 SHALL have port clr_ovf  input  1  clears sticky overflow.
REQ-012 SHALL have port rd_valid  output  1  FIFO non-empty; head entry presented.
REQ-013 SHALL have port rd_data  output  DATA_W  head value.
REQ-014 SHALL have port rd_ch  output  $clog2(NUM_CH) (min 1)  head channel index.
REQ-015 SHALL have port rd_ts  output  TS_W  head timestamp.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-017 SHALL have port overflow  output  1  sticky loss flag.

Function
REQ-018 SHALL detect an event on channel i at edge k when cap_en & watch_valid[i] & (watch_data_i != last_i | first_i); it then SHALL update last_i, clear first_i, set pending_i with value and the current timestamp.
REQ-019 SHALL, when cap_en=0, detect no events and leave last_i/first_i unchanged; existing pending entries SHALL still drain.
REQ-020 SHALL write at most one pending entry per cycle into the FIFO, fixed priority, lowest channel index first; the written pending_i SHALL clear at the same edge.
REQ-021 SHALL have latency: event sampled at edge k, FIFO write at edge k+1 at earliest, rd_valid=1 after edge k+1 when FIFO was empty and no lower-index channel is pending.
REQ-022 SHALL, on a new event on channel i while pending_i is set and not written that edge, overwrite pending_i and set overflow.
REQ-023 SHALL, when the FIFO is full and no pop occurs, discard the selected pending entry, clear it, and set overflow.
REQ-024 SHALL accept a write when full if rd_en & rd_valid in the same cycle; count unchanged.
REQ-025 SHALL operate show-ahead: rd_data/rd_ch/rd_ts valid whenever rd_valid=1; rd_en with rd_valid=1 pops at that edge; rd_en with rd_valid=0 ignored.
REQ-026 SHALL wrap read/write pointers modulo DEPTH; count = writes minus pops, range 0..DEPTH.
REQ-027 SHALL hold overflow until clr_ovf or rst; clr_ovf and a new loss in the same cycle SHALL leave overflow=1.
REQ-028 SHALL run the timestamp counter free, +1 per cycle, wrapping from 2^TS_W-1 to 0.

Reset
REQ-029 SHALL, while rst=1, clear FIFO, pointers, pending, overflow, timestamp; set all first_i=1; outputs rd_valid=0, count=0, overflow=0, rd_data/rd_ch/rd_ts=0.
REQ-030 SHALL discard all queued and pending entries when rst asserts mid-operation; rst overrides every other input.

Configuration
REQ-031 SHALL, with macro TRACE_TIMESTAMP_EN defined, implement the TS_W counter and store timestamps per entry.
REQ-032 SHALL, without TRACE_TIMESTAMP_EN, omit counter and timestamp storage; rd_ts SHALL be constant 0; all other behaviour identical.

Structure
REQ-033 SHALL place the entry record type (value, channel, timestamp) and the channel-index width function in shared package trace_pkg.
REQ-034 SHALL implement storage as sub-module trace_fifo (synchronous, show-ahead, DEPTH parameter, full/empty/count).

Verification
REQ-035 SHALL cover: after rst, ch0 valid with 0x5 on two consecutive cycles -> one entry {0x5, ch0}, rd_valid after 2nd edge, count=1.
REQ-036 SHALL cover: ch1=0xA and ch3=0xB events at the same edge -> ch1 entry written first, ch3 one cycle later, rd_ts of both equal.
REQ-037 SHALL cover: DEPTH=16 with no reads, 17 distinct ch0 values -> count=16, overflow=1, head = first value; clr_ovf -> overflow=0.
REQ-038 SHALL cover: full FIFO with rd_en=1 and a new event the same cycle -> count stays 16, new entry at tail.
REQ-039 SHALL cover: cap_en=0 with changing inputs for 10 cycles -> count=0; rst during a queued burst -> rd_valid=0 the following cycle.
REQ-040 SHALL cover: TS_W=4 run 20 cycles -> timestamps wrap 15 to 0; build without TRACE_TIMESTAMP_EN -> rd_ts=0.
